// File: rtl/ram_io_responder.sv
// Memory-side responder for the CPU byte bus: byte-addressed block RAM plus an
// I/O region holding a UART transmit FIFO, a receive port, a status register
// and a sticky halt flag. Read data comes back one cycle after the address.
module ram_io_responder #(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int TX_DEPTH_WIDTH = 4,
  parameter int FULL_MARGIN    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        halt,
  output logic [7:0]  tx_drop_cnt
);

  localparam int                      DEPTH      = 1 << TX_DEPTH_WIDTH;
  localparam logic [TX_DEPTH_WIDTH:0] DEPTH_C    = (TX_DEPTH_WIDTH + 1)'(DEPTH);
  localparam logic [TX_DEPTH_WIDTH:0] FULL_LEVEL = (TX_DEPTH_WIDTH + 1)'(DEPTH - FULL_MARGIN);
  localparam logic [TX_DEPTH_WIDTH:0] CNT_ONE    = (TX_DEPTH_WIDTH + 1)'(1);
  localparam logic [TX_DEPTH_WIDTH-1:0] PTR_ONE  = TX_DEPTH_WIDTH'(1);
  localparam logic [17:0]             TX_ADDR     = 18'h30000;
  localparam logic [17:0]             STATUS_ADDR = 18'h30004;

  // Which register drives mem_din after a read.
  typedef enum logic {
    SRC_IO,
    SRC_RAM
  } rd_src_e;

  // Address decode: only the low 18 bits of the CPU address are meaningful.
  logic [17:0]               addr;
  logic                      is_io;
  logic [RAM_ADDR_WIDTH-1:0] ram_idx;
  logic                      unused_addr_bits;

  assign addr             = mem_a[17:0];
  assign is_io            = (addr[17:16] == 2'b11);
  assign ram_idx          = mem_a[RAM_ADDR_WIDTH-1:0];
  assign unused_addr_bits = ^mem_a[31:18];

  // Bus strobes, all qualified by rdy so a stalled cycle changes nothing.
  logic ram_we, ram_re;
  logic push_req, push_ok, pop, halt_wr;

  assign ram_we   = rst & rdy & mem_wr & ~is_io;
  assign ram_re   = rdy & ~mem_wr & ~is_io;
  assign push_req = rdy & mem_wr & is_io & (addr == TX_ADDR);
  assign halt_wr  = rdy & mem_wr & is_io & (addr == STATUS_ADDR);
  assign rx_ready = rst & rdy & is_io & ~mem_wr & (addr == TX_ADDR) & rx_valid;

  // Storage and state registers.
  logic [7:0] mem_q  [2**RAM_ADDR_WIDTH];
  logic [7:0] fifo_q [DEPTH];
  logic [7:0] ram_rd_q;

  logic [TX_DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [TX_DEPTH_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [TX_DEPTH_WIDTH:0]   count_q, count_d;
  logic                      full_q, full_d;
  logic                      halt_q, halt_d;
  logic [7:0]                drop_q, drop_d;
  rd_src_e                   rd_src_q, rd_src_d;
  logic [7:0]                io_rd_q, io_rd_d;
  logic                      tx_full;

  assign tx_full = (count_q == DEPTH_C);
  assign push_ok = push_req & (count_q < DEPTH_C);
  assign pop     = tx_valid & tx_ready & rdy;

  // RAM write port and registered read port.
  // NOTE: memory arrays carry no reset; clearing them would prevent block-RAM
  // mapping, and the bus never reads a location before writing it.
  always_ff @(posedge clk) begin
    if (ram_we) mem_q[ram_idx] <= mem_dout;
    if (ram_re) ram_rd_q <= mem_q[ram_idx];
  end

  // TX FIFO storage write; occupancy is tracked by the control registers.
  always_ff @(posedge clk) begin
    if (rst && push_ok) fifo_q[wr_ptr_q] <= mem_dout;
  end

  // Next-state logic for the FIFO control, flags and I/O read data.
  // NOTE: every output of this block is given its hold value first so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    halt_d   = halt_q | halt_wr;
    rd_src_d = rd_src_q;
    io_rd_d  = io_rd_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;

    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (push_req && !push_ok && drop_q != 8'hFF) drop_d = drop_q + 8'd1;

    if (rdy && !mem_wr) begin
      if (is_io) begin
        rd_src_d = SRC_IO;
        if (addr == TX_ADDR)          io_rd_d = rx_valid ? rx_data : 8'h00;
        else if (addr == STATUS_ADDR) io_rd_d = {6'b0, rx_valid, tx_full};
        else                          io_rd_d = 8'h00;
      end else begin
        rd_src_d = SRC_RAM;
      end
    end

    full_d = (count_d >= FULL_LEVEL);
  end

  // Control register update with synchronous active-low reset.
  // NOTE: state registers use non-blocking assignment so every register
  // samples the pre-edge values computed above.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      halt_q   <= 1'b0;
      drop_q   <= 8'h00;
      rd_src_q <= SRC_IO;
      io_rd_q  <= 8'h00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      halt_q   <= halt_d;
      drop_q   <= drop_d;
      rd_src_q <= rd_src_d;
      io_rd_q  <= io_rd_d;
    end
  end

  assign mem_din        = (rd_src_q == SRC_RAM) ? ram_rd_q : io_rd_q;
  assign io_buffer_full = full_q;
  assign tx_valid       = (count_q != '0);
  assign tx_data        = fifo_q[rd_ptr_q];
  assign halt           = halt_q;
  assign tx_drop_cnt    = drop_q;

endmodule

// File: tb/tb_ram_io_responder.sv
// Bench for ram_io_responder: a driver issues one bus cycle at a time and
// updates a queue/array reference model; a negedge monitor pops expected
// per-cycle state and expected TX bytes and compares them with the DUT.
module tb_ram_io_responder;

  localparam int          DEPTH  = 16;
  localparam int          MARGIN = 2;
  localparam logic [17:0] TX_A   = 18'h30000;
  localparam logic [17:0] ST_A   = 18'h30004;

  logic        clk = 1'b1;
  logic        rst, rdy, mem_wr, tx_ready, rx_valid;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout, rx_data;
  logic [7:0]  mem_din, tx_data, tx_drop_cnt;
  logic        io_buffer_full, tx_valid, rx_ready, halt;

  ram_io_responder dut (
    .clk(clk), .rst(rst), .rdy(rdy), .mem_a(mem_a), .mem_dout(mem_dout),
    .mem_wr(mem_wr), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .halt(halt), .tx_drop_cnt(tx_drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         chk;
    bit         din_chk;
    logic [7:0] din;
    bit         tx_valid;
    bit         full;
    bit         halt;
    logic [7:0] drop;
    bit         rx_ready;
  } rec_t;

  int         tests = 0;
  int         fails = 0;
  rec_t       recs[$];
  logic [7:0] tx_exp[$];

  // Reference model state.
  logic [7:0] mq[$];
  logic [7:0] ram_m[int];
  bit         m_known = 0;
  bit         m_halt;
  logic [7:0] m_drop;
  logic [7:0] m_din;
  bit         m_din_known = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // One bus cycle: drive inputs, record expected visible state, advance model.
  task automatic cycle(input bit r, input bit rd_y, input bit wr, input logic [31:0] a,
                       input logic [7:0] d, input bit txr, input bit rxv, input logic [7:0] rxd);
    rec_t        rec;
    logic [17:0] a18;
    bit          io;
    int          pre;
    int          idx;
    a18 = a[17:0];
    io  = (a18[17:16] == 2'b11);
    idx = int'(a[16:0]);
    rst = r; rdy = rd_y; mem_wr = wr; mem_a = a; mem_dout = d;
    tx_ready = txr; rx_valid = rxv; rx_data = rxd;

    rec.chk      = m_known;
    rec.din_chk  = m_known && m_din_known;
    rec.din      = m_din;
    rec.tx_valid = (mq.size() != 0);
    rec.full     = (mq.size() >= DEPTH - MARGIN);
    rec.halt     = m_halt;
    rec.drop     = m_drop;
    rec.rx_ready = r && rd_y && !wr && io && (a18 == TX_A) && rxv;
    recs.push_back(rec);

    if (!r) begin
      mq.delete();
      m_halt = 0; m_drop = 8'h00; m_din = 8'h00;
      m_din_known = 1; m_known = 1;
    end else if (rd_y) begin
      pre = mq.size();
      if (txr && pre != 0) tx_exp.push_back(mq.pop_front());
      if (wr) begin
        if (io) begin
          if (a18 == TX_A) begin
            if (pre < DEPTH) mq.push_back(d);
            else if (m_drop != 8'hFF) m_drop++;
          end else if (a18 == ST_A) begin
            m_halt = 1;
          end
        end else begin
          ram_m[idx] = d;
        end
        m_din_known = 0;
      end else if (io) begin
        if (a18 == TX_A)      m_din = rxv ? rxd : 8'h00;
        else if (a18 == ST_A) m_din = {6'b0, rxv, (pre == DEPTH)};
        else                  m_din = 8'h00;
        m_din_known = 1;
      end else if (ram_m.exists(idx)) begin
        m_din = ram_m[idx];
        m_din_known = 1;
      end else begin
        m_din_known = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Ignored I/O write: advances time and lets the FIFO drain when txr is set.
  task automatic nop(input bit txr);
    cycle(1, 1, 1, 32'h0003000C, 8'h00, txr, 0, 8'h00);
  endtask

  task automatic stall();
    cycle(1, 0, 0, 32'h00000000, 8'h00, 0, 0, 8'h00);
  endtask

  // Monitor: compare visible state each cycle and TX bytes on each handshake.
  always @(negedge clk) begin
    rec_t r;
    if (recs.size() > 0) begin
      r = recs.pop_front();
      if (r.chk) begin
        check("tx_valid", tx_valid, r.tx_valid);
        check("io_buffer_full", io_buffer_full, r.full);
        check("halt", halt, r.halt);
        check("tx_drop_cnt", tx_drop_cnt, r.drop);
      end
      if (r.din_chk) check("mem_din", mem_din, r.din);
      check("rx_ready", rx_ready, r.rx_ready);
    end
    if (rst === 1'b1 && rdy === 1'b1 && tx_valid === 1'b1 && tx_ready === 1'b1) begin
      if (tx_exp.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL tx_pop at %0t: DUT popped 0x%0h, expected no pop", $time, tx_data);
      end else begin
        check("tx_data", tx_data, tx_exp.pop_front());
      end
    end
  end

  logic [15:0] ram_slots[8] = '{16'h0010, 16'h0011, 16'h1234, 16'h7FFF,
                                16'h8000, 16'hABCD, 16'hFFFE, 16'h0000};

  initial begin
    logic [31:0] r32;
    logic [17:0] a18;
    int          kind;
    int          idx;

    // Reset, then RAM write/read with a stall cycle to observe the read data.
    repeat (3) cycle(0, 1, 0, 32'h0, 8'h00, 0, 1, 8'h55);
    cycle(1, 1, 1, 32'h00000010, 8'hA5, 0, 0, 8'h00);
    cycle(1, 1, 0, 32'h00000010, 8'h00, 0, 0, 8'h00);
    stall();
    stall();
    // High address bits above bit 17 are ignored; bank 2 aliases bank 0.
    cycle(1, 1, 1, 32'hFFFA0010, 8'h3C, 0, 0, 8'h00);
    cycle(1, 1, 0, 32'h00000010, 8'h00, 0, 0, 8'h00);
    stall();

    // TX fill with the sink stalled.
    repeat (14) cycle(1, 1, 1, {14'h0, TX_A}, 8'h41, 0, 0, 8'h00);
    stall();
    repeat (2) cycle(1, 1, 1, {14'h0, TX_A}, 8'h41, 0, 0, 8'h00);
    cycle(1, 1, 0, {14'h0, ST_A}, 8'h00, 0, 0, 8'h00);
    stall();
    cycle(1, 1, 1, {14'h0, TX_A}, 8'h42, 0, 0, 8'h00);
    stall();
    // Full FIFO with push and pop together: pop happens, push is dropped.
    cycle(1, 1, 1, {14'h0, TX_A}, 8'h43, 1, 0, 8'h00);
    stall();
    while (mq.size() != 0) nop(1);

    // Wrap-around: interleaved pushes and pops keep push order.
    for (int i = 0; i < 40; i++) cycle(1, 1, 1, {14'h0, TX_A}, 8'(i + 8'h80), i[0], 0, 8'h00);
    while (mq.size() != 0) nop(1);

    // RX port with and without a byte available.
    cycle(1, 1, 0, {14'h0, TX_A}, 8'h00, 0, 1, 8'h7E);
    stall();
    cycle(1, 1, 0, {14'h0, TX_A}, 8'h00, 0, 0, 8'h99);
    stall();
    cycle(1, 1, 0, {14'h0, ST_A}, 8'h00, 0, 1, 8'h00);
    stall();

    // rdy low blocks push and halt; then halt is set and sticks.
    cycle(1, 0, 1, {14'h0, TX_A}, 8'h11, 1, 0, 8'h00);
    cycle(1, 0, 1, {14'h0, ST_A}, 8'h00, 1, 0, 8'h00);
    stall();
    cycle(1, 1, 1, {14'h0, ST_A}, 8'h00, 0, 0, 8'h00);
    repeat (3) nop(1);

    // Populate RAM slots for randomized reads.
    for (int i = 0; i < 8; i++) cycle(1, 1, 1, {15'h0, 1'b0, ram_slots[i]}, 8'(i * 37 + 5), 0, 0, 8'h00);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      r32  = $urandom();
      kind = $urandom_range(0, 9);
      if ($urandom_range(0, 199) == 0) begin
        cycle(0, 1, 0, 32'h0, 8'h00, 1, 0, 8'h00);
        continue;
      end
      if (kind <= 4 || kind == 9) begin
        a18 = {2'($urandom_range(0, 2)), ram_slots[$urandom_range(0, 7)]};
      end else if (kind <= 6) begin
        a18 = TX_A;
      end else if (kind == 7) begin
        a18 = ST_A;
      end else begin
        a18 = TX_A + 18'h8 + 18'($urandom_range(0, 16'hFFF0));
      end
      idx = int'(a18[16:0]);
      cycle(1, ($urandom_range(0, 9) != 0),
            (($urandom_range(0, 1) == 1) || (a18[17:16] != 2'b11 && !ram_m.exists(idx))),
            {r32[31:18], a18}, 8'($urandom_range(0, 255)),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1), 8'($urandom_range(0, 255)));
    end

    while (mq.size() != 0) nop(1);
    nop(0);
    check("tx_exp_drained", tx_exp.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
